// File: rtl/square_period_meter.sv
// Square-wave period / high-time meter: synchronizes an asynchronous wave and measures
// rising-to-rising period and high time in clk cycles, with overflow and lock flags.
module square_period_meter #(
  parameter int unsigned CW   = 16,
  parameter int unsigned SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          wave_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          overflow,
  output logic          locked
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, OVF} state_t;

  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_MAX = '1;

  logic [SYNC-1:0] r_sync;
  logic            r_ws_d;
  logic            w_ws;
  logic            w_rise;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [CW-1:0]   r_hcnt, w_hcnt_n;
  logic [CW-1:0]   r_period, w_period_n;
  logic [CW-1:0]   r_high, w_high_n;
  logic            r_valid, w_valid_n;
  logic            r_ovf, w_ovf_n;
  logic            r_locked, w_locked_n;

  assign w_ws   = r_sync[SYNC-1];
  assign w_rise = w_ws & ~r_ws_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_ws_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], wave_in};
      r_ws_d <= w_ws;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hcnt   <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_hcnt   <= w_hcnt_n;
      r_period <= w_period_n;
      r_high   <= w_high_n;
      r_valid  <= w_valid_n;
      r_ovf    <= w_ovf_n;
      r_locked <= w_locked_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_hcnt_n   = r_hcnt;
    w_period_n = r_period;
    w_high_n   = r_high;
    w_valid_n  = 1'b0;
    w_ovf_n    = r_ovf;
    w_locked_n = r_locked;

    // Losing enable wins over any edge seen this cycle; results and overflow are kept.
    if (!ena) begin
      w_state_n  = IDLE;
      w_cnt_n    = '0;
      w_hcnt_n   = '0;
      w_locked_n = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_cnt_n   = '0;
          w_hcnt_n  = '0;
          w_state_n = ARM;
        end
        ARM: begin
          if (w_rise) begin
            w_cnt_n   = C_ONE;
            w_hcnt_n  = C_ONE;
            w_state_n = MEASURE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_period_n = r_cnt;
            w_high_n   = r_hcnt;
            w_valid_n  = 1'b1;
            w_locked_n = 1'b1;
            w_ovf_n    = 1'b0;
            w_cnt_n    = C_ONE;
            w_hcnt_n   = C_ONE;
          end else if (r_cnt == C_MAX) begin
            w_state_n = OVF;
            w_ovf_n   = 1'b1;
          end else begin
            w_cnt_n = r_cnt + C_ONE;
            if (w_ws) w_hcnt_n = r_hcnt + C_ONE;
          end
        end
        OVF: begin
          if (w_rise) begin
            w_cnt_n   = C_ONE;
            w_hcnt_n  = C_ONE;
            w_state_n = MEASURE;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign overflow  = r_ovf;
  assign locked    = r_locked;

endmodule

// File: tb/tb_square_period_meter.sv
// Scoreboard bench for square_period_meter: a 16-bit and an 8-bit instance see the same
// wave; each expected measurement is queued at the wave's rising edge and popped on valid.
module tb_square_period_meter;

  logic clk = 1'b0;
  logic rst, ena, wave_in;

  logic [15:0] p16, h16;
  logic        v16, o16, l16;
  logic [7:0]  p8, h8;
  logic        v8, o8, l8;

  always #5 clk = ~clk;

  square_period_meter #(.CW(16), .SYNC(2)) dut16 (
    .clk(clk), .rst(rst), .ena(ena), .wave_in(wave_in),
    .period(p16), .high_time(h16), .valid(v16), .overflow(o16), .locked(l16)
  );

  square_period_meter #(.CW(8), .SYNC(2)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .wave_in(wave_in),
    .period(p8), .high_time(h8), .valid(v8), .overflow(o8), .locked(l8)
  );

  typedef struct {
    int p;
    int h;
    int tol;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  int checks   = 0;
  int failures = 0;

  // Model of the stimulus history: a measurement is expected at a rise only when the
  // meter was already armed and the preceding period fits the counter width.
  bit armed     = 1'b0;
  bit have_prev = 1'b0;
  int prev_p    = 0;
  int prev_h    = 0;
  int tol       = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int req, input int t);
    checks++;
    if (act > req + t || act < req - t) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (+/-%0d)", name, act, req, t);
    end
  endtask

  task automatic rise_evt();
    if (armed && have_prev) begin
      if (prev_p <= 65535) q16.push_back('{p: prev_p, h: prev_h, tol: tol});
      if (prev_p <= 255)   q8.push_back('{p: prev_p, h: prev_h, tol: tol});
    end
    armed = 1'b1;
  endtask

  task automatic seg(input int h, input int l);
    rise_evt();
    wave_in = 1'b1;
    repeat (h) @(negedge clk);
    wave_in = 1'b0;
    repeat (l) @(negedge clk);
    prev_p = h + l; prev_h = h; have_prev = 1'b1;
  endtask

  task automatic aseg(input int h, input int l);
    rise_evt();
    wave_in = 1'b1;
    #(h * 10);
    wave_in = 1'b0;
    #(l * 10);
    prev_p = h + l; prev_h = h; have_prev = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (v16) begin
      if (q16.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut16_unexpected_valid actual=valid(%0d/%0d) required=no_valid", p16, h16);
      end else begin
        e = q16.pop_front();
        chk_tol("dut16_period", int'(p16), e.p, e.tol);
        chk_tol("dut16_high_time", int'(h16), e.h, e.tol);
        chk("dut16_locked_at_valid", int'(l16), 1);
        chk("dut16_overflow_at_valid", int'(o16), 0);
      end
    end
    if (v8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut8_unexpected_valid actual=valid(%0d/%0d) required=no_valid", p8, h8);
      end else begin
        e = q8.pop_front();
        chk_tol("dut8_period", int'(p8), e.p, e.tol);
        chk_tol("dut8_high_time", int'(h8), e.h, e.tol);
        chk("dut8_locked_at_valid", int'(l8), 1);
        chk("dut8_overflow_at_valid", int'(o8), 0);
      end
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; wave_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period16", int'(p16), 0);
    chk("reset_high16", int'(h16), 0);
    chk("reset_valid16", int'(v16), 0);
    chk("reset_overflow16", int'(o16), 0);
    chk("reset_locked16", int'(l16), 0);
    chk("reset_period8", int'(p8), 0);
    chk("reset_locked8", int'(l8), 0);
    rst = 1'b0; ena = 1'b1;
    repeat (5) @(negedge clk);

    repeat (6) seg(4, 4);
    repeat (3) seg(3, 7);
    repeat (3) seg(5, 1);
    repeat (2) seg(10, 10);
    chk("locked16_after_runs", int'(l16), 1);
    chk("locked8_after_runs", int'(l8), 1);

    // Long low stretch: 8-bit instance overflows, 16-bit one measures 304.
    seg(4, 300);
    chk("ovf8_set", int'(o8), 1);
    chk("ovf8_period_held", int'(p8), 20);
    chk("ovf16_clear", int'(o16), 0);
    seg(10, 10);
    chk("ovf8_still_set", int'(o8), 1);
    repeat (2) seg(10, 10);
    chk("ovf8_cleared", int'(o8), 0);
    chk("p8_after_resume", int'(p8), 20);

    ena = 1'b0;
    @(negedge clk);
    chk("locked16_ena_drop", int'(l16), 0);
    chk("locked8_ena_drop", int'(l8), 0);
    armed = 1'b0;
    repeat (3) @(negedge clk);
    chk("period16_held_idle", int'(p16), 20);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    repeat (3) seg(6, 6);

    rise_evt();
    wave_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_period16", int'(p16), 0);
    chk("rst_mid_high16", int'(h16), 0);
    chk("rst_mid_valid16", int'(v16), 0);
    chk("rst_mid_locked16", int'(l16), 0);
    chk("rst_mid_overflow8", int'(o8), 0);
    chk("rst_mid_period8", int'(p8), 0);
    wave_in = 1'b0;
    armed = 1'b0; have_prev = 1'b0;
    repeat (6) @(negedge clk);
    repeat (3) seg(7, 3);

    tol = 1;
    #3;
    repeat (4) aseg(5, 4);
    #7;
    repeat (30) @(negedge clk);

    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/square_period_meter.md
SQUARE_PERIOD_METER -- requirements
Module: square_period_meter

Interface
REQ-001 Parameter CW, default 16, SHALL set the width of all cycle counters and measurement outputs.
REQ-002 Parameter SYNC, default 2, SHALL set the number of input synchronizer flops; legal range 2..4.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 ena  input  1  SHALL enable measurement when high.
REQ-006 wave_in  input  1  SHALL be the asynchronous square wave under measurement.
REQ-007 period  output  CW  SHALL hold the last complete rising-to-rising period, in clk cycles.
REQ-008 high_time  output  CW  SHALL hold the cycles wave was high within that period.
REQ-009 valid  output  1  SHALL pulse high for one cycle when period/high_time update.
REQ-010 overflow  output  1  SHALL flag a period exceeding 2^CW-1 cycles.
REQ-011 locked  output  1  SHALL be high once at least one valid measurement exists since reset or ena loss.

Function
REQ-012 wave_in SHALL pass through SYNC flops; the result is ws, with a further flop ws_d for edge detection.
REQ-013 A rising edge SHALL be detected in a cycle where ws=1 and ws_d=0; falling edges are ignored except via high counting.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE, OVF.
REQ-015 IDLE: entered on reset or when ena=0; counters cleared; on ena=1, the FSM SHALL go to ARM next cycle.
REQ-016 ARM: on a rising edge, the FSM SHALL clear cnt to 1 and hcnt to 1, then go to MEASURE; no valid is emitted.
REQ-017 MEASURE, no edge: cnt SHALL increment by 1; hcnt SHALL increment by 1 when ws=1.
REQ-018 MEASURE, on edge: period SHALL load cnt and high_time SHALL load hcnt; valid=1 for that one cycle; locked=1; overflow=0; cnt=1 and hcnt=1 restart; state stays MEASURE.
REQ-019 For an ideal input of P cycles with H high cycles, period SHALL equal P and high_time SHALL equal H.
REQ-020 Valid latency SHALL be SYNC+1 clk cycles after the first clk edge that samples wave_in high.
REQ-021 MEASURE: if cnt reaches 2^CW-1 with no edge, the FSM SHALL go to OVF and set overflow=1; period/high_time keep their old values.
REQ-022 OVF: counters SHALL be held; on a rising edge, the FSM SHALL clear cnt/hcnt to 1 and go to MEASURE with no valid; overflow stays 1 until the next valid.
REQ-023 hcnt SHALL never exceed cnt; hcnt saturation SHALL follow cnt.
REQ-024 ena falling: the FSM SHALL go to IDLE next cycle; locked cleared; period, high_time and overflow SHALL hold; any partial measurement is discarded.
REQ-025 An edge in the same cycle that ena drops SHALL NOT produce valid.
REQ-026 Constant-high or constant-low input SHALL yield no valid, eventually followed by overflow.

Reset
REQ-027 On rst=1 at a clk edge: state=IDLE; period=0; high_time=0; valid=0; overflow=0; locked=0; synchronizer flops=0; cnt=hcnt=0.
REQ-028 rst SHALL override ena and edge detection in the same cycle; a reset mid-measurement discards the partial count.

Verification
REQ-029 CW=16; wave 8-cycle period, 4 high, ena=1 -> first valid after the second rising edge; period=8, high_time=4; valid every 8 cycles; locked=1.
REQ-030 Wave 10-cycle period, 3 high -> period=10, high_time=3; then switch to 6/5 -> next valid reports 6/5.
REQ-031 CW=8; wave held low 300 cycles after lock -> overflow=1 at cnt=255, period holds prior value; after resume at 20/10 -> overflow stays 1 until the first valid 20/10, then 0.
REQ-032 ena dropped mid-period -> locked=0 next cycle, no valid; re-enable -> first valid only after two further rising edges.
REQ-033 rst pulsed mid-measurement -> all outputs 0 next cycle; measurement resumes only after ena and two rising edges.
REQ-034 wave_in toggled asynchronously, with edges offset from clk -> period within +/-1 of nominal; no spurious valid pulses.
